// File: rtl/rom_burst_reader_if.sv
// rom_burst_reader_if: ROM read bus plus the valid/ready word stream of the burst reader.
interface rom_burst_reader_if #(parameter int ADDR_W = 3, parameter int DATA_W = 32);
  logic [ADDR_W-1:0] rom_addr;
  logic rom_oe;
  wire [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output rom_addr, rom_oe, out_data, out_valid, input rom_data, out_ready);
  modport slave (input rom_addr, rom_oe, out_data, out_valid, output out_ready);
endinterface

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: reads a burst of consecutive ROM words and streams them over valid/ready.
// Optional ROM_READ_CHECKSUM_EN adds an XOR checksum of every word captured in the burst.
module rom_burst_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0] count,
  output logic busy,
  output logic done,
`ifdef ROM_READ_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  rom_burst_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] rom_addr, rom_addr_n;
  logic rom_oe, rom_oe_n, out_valid, out_valid_n, busy_n, done_n;
  logic [DATA_W-1:0] out_data, out_data_n;
  logic [ADDR_W:0] remaining, remaining_n;
  logic [3:0] wcnt, wcnt_n;
`ifdef ROM_READ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_n;
`endif
  assign bus.rom_addr = rom_addr;
  assign bus.rom_oe = rom_oe;
  assign bus.out_data = out_data;
  assign bus.out_valid = out_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rom_addr <= '0;
      rom_oe <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      remaining <= '0;
      wcnt <= '0;
`ifdef ROM_READ_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      state <= state_n;
      rom_addr <= rom_addr_n;
      rom_oe <= rom_oe_n;
      out_data <= out_data_n;
      out_valid <= out_valid_n;
      busy <= busy_n;
      done <= done_n;
      remaining <= remaining_n;
      wcnt <= wcnt_n;
`ifdef ROM_READ_CHECKSUM_EN
      checksum <= checksum_n;
`endif
    end
  always_comb begin
    state_n = state;
    rom_addr_n = rom_addr;
    rom_oe_n = rom_oe;
    out_data_n = out_data;
    out_valid_n = out_valid;
    busy_n = busy;
    done_n = 1'b0;
    remaining_n = remaining;
    wcnt_n = wcnt;
`ifdef ROM_READ_CHECKSUM_EN
    checksum_n = checksum;
`endif
    case (state)
      IDLE:
        if (start) begin
          rom_addr_n = start_addr;
          rom_oe_n = 1'b1;
          remaining_n = count == '0 ? (ADDR_W+1)'(2**ADDR_W) : count;
          wcnt_n = 4'(WAIT_CYCLES);
          busy_n = 1'b1;
          state_n = WAIT;
`ifdef ROM_READ_CHECKSUM_EN
          checksum_n = '0;
`endif
        end
      WAIT: begin
        wcnt_n = wcnt - 4'd1;
        // rom_data is only sampled here, while rom_oe is still high
        if (wcnt == 4'd1) begin
          out_data_n = bus.rom_data;
          out_valid_n = 1'b1;
          rom_oe_n = 1'b0;
          state_n = OUT;
`ifdef ROM_READ_CHECKSUM_EN
          checksum_n = checksum ^ bus.rom_data;
`endif
        end
      end
      OUT:
        if (out_valid && bus.out_ready) begin
          out_valid_n = 1'b0;
          remaining_n = remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            busy_n = 1'b0;
            done_n = 1'b1;
            state_n = IDLE;
          end else begin
            rom_addr_n = rom_addr + 1'b1;
            rom_oe_n = 1'b1;
            wcnt_n = 4'(WAIT_CYCLES);
            state_n = WAIT;
          end
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: directed checks of rom_burst_reader against a Z-releasing ROM model.
module tb_rom_burst_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done;
  logic [2:0] start_addr = '0;
  logic [3:0] count = '0;
  int checks = 0, errors = 0, dones = 0;
  logic [31:0] rom [8] = '{32'h0986ab68, 32'h10385ba9, 32'h3f800000, 32'h3e800000,
                           32'h40400000, 32'h41200000, 32'h3ea00000, 32'h3f600000};
  logic [31:0] qd [$];
  logic [2:0] qa [$];
  rom_burst_reader_if #(3, 32) bus ();
  assign bus.rom_data = bus.rom_oe ? rom[bus.rom_addr] : 'z;
`ifdef ROM_READ_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  rom_burst_reader #(.ADDR_W(3), .DATA_W(32), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
    .busy(busy), .done(done),
`ifdef ROM_READ_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      qd.push_back(bus.out_data);
      qa.push_back(bus.rom_addr);
    end
    if (done) dones++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic go(input logic [2:0] a, input logic [3:0] n);
    qd.delete();
    qa.delete();
    dones = 0;
    start = 1'b1;
    start_addr = a;
    count = n;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
    tick();
  endtask
  initial begin
    bus.out_ready = 1'b1;
    #1;
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_oe", 32'(bus.rom_oe), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_oe", 32'(bus.rom_oe), 0);
    chk("idle_busy", 32'(busy), 0);
    go(3'd2, 4'd1);
    chk("s_busy", 32'(busy), 1);
    chk("s_oe", 32'(bus.rom_oe), 1);
    chk("s_addr", 32'(bus.rom_addr), 2);
    chk("s_valid0", 32'(bus.out_valid), 0);
    tick();
    chk("s_valid1", 32'(bus.out_valid), 1);
    chk("s_data", bus.out_data, 32'h3f800000);
    chk("s_oe_off", 32'(bus.rom_oe), 0);
    tick();
    chk("s_done", 32'(done), 1);
    chk("s_busy_off", 32'(busy), 0);
    chk("s_valid_off", 32'(bus.out_valid), 0);
    tick();
    chk("s_done_off", 32'(done), 0);
    chk("s_dones", 32'(dones), 1);
    go(3'd6, 4'd4);
    wait_done("wrap");
    chk("w_n", 32'(qd.size()), 4);
    for (int i = 0; i < 4 && i < qd.size(); i++) begin
      chk($sformatf("w_data%0d", i), qd[i], rom[(6 + i) % 8]);
      chk($sformatf("w_addr%0d", i), 32'(qa[i]), 32'((6 + i) % 8));
    end
    chk("w_dones", 32'(dones), 1);
`ifdef ROM_READ_CHECKSUM_EN
    chk("w_cks", checksum, 32'h3ea00000 ^ 32'h3f600000 ^ 32'h0986ab68 ^ 32'h10385ba9);
`endif
    bus.out_ready = 1'b0;
    go(3'd4, 4'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", bus.out_data, 32'h40400000);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_oe", 32'(bus.rom_oe), 0);
    end
    bus.out_ready = 1'b1;
    wait_done("bp");
    chk("bp_n", 32'(qd.size()), 2);
    if (qd.size() == 2) begin
      chk("bp_w0", qd[0], 32'h40400000);
      chk("bp_w1", qd[1], 32'h41200000);
    end
    go(3'd0, 4'd0);
    repeat (3) tick();
    start = 1'b1;
    start_addr = 3'd5;
    count = 4'd1;
    tick();
    start = 1'b0;
    wait_done("all");
    chk("a_n", 32'(qd.size()), 8);
    for (int i = 0; i < 8 && i < qd.size(); i++) chk($sformatf("a_data%0d", i), qd[i], rom[i]);
    repeat (4) tick();
    chk("a_dones", 32'(dones), 1);
    chk("a_busy", 32'(busy), 0);
    go(3'd1, 4'd4);
    for (int n = 0; qd.size() < 2 && n < 200; n++) tick();
    chk("m_oe", 32'(bus.rom_oe), 1);
    chk("m_addr", 32'(bus.rom_addr), 3);
    rst_n = 1'b0;
    #1;
    chk("m_rst_oe", 32'(bus.rom_oe), 0);
    chk("m_rst_addr", 32'(bus.rom_addr), 0);
    chk("m_rst_data", bus.out_data, 0);
    chk("m_rst_valid", 32'(bus.out_valid), 0);
    chk("m_rst_busy", 32'(busy), 0);
    repeat (2) tick();
    chk("m_dones", 32'(dones), 0);
    rst_n = 1'b1;
    tick();
    go(3'd3, 4'd1);
    wait_done("m_new");
    chk("m_new_n", 32'(qd.size()), 1);
    if (qd.size() == 1) chk("m_new_w", qd[0], 32'h3e800000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
